// File: rtl/rk4_axis_stall_detector_if.sv
// Bundle of the monitored AXI-Stream handshake lines, one bit per channel.
//   ch_tvalid  NUM_CH  TVALID of each channel
//   ch_tready  NUM_CH  TREADY of each channel
// master/slave are the real endpoints of the streams; monitor is read-only
// and is what the stall detector binds to, so it can never disturb the datapath.
interface rk4_axis_stall_detector_if #(
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0] ch_tvalid;
  logic [NUM_CH-1:0] ch_tready;

  modport master  (output ch_tvalid, input  ch_tready);
  modport slave   (input  ch_tvalid, output ch_tready);
  modport monitor (input  ch_tvalid, input  ch_tready);
endinterface

// File: rtl/rk4_axis_stall_detector.sv
// Per-channel AXIS stall detector feeding the RK4 deadlock monitor.
// Each channel counts consecutive stall cycles and raises its block flag
// once the count reaches STALL_THRESH. The first channel to block is
// latched, along with its stall count, for debug readout until cleared.
// Ports:
//   clock, reset      clock, synchronous active-high reset
//   enable            monitoring active; 0 clears all counters/flags
//   clear             pulse, releases the latched report
//   axis              monitor modport carrying ch_tvalid / ch_tready
//   axis_block_sigs   registered per-channel blocked flags
//   any_block         registered OR of the block flags
//   first_valid       report latched
//   first_ch          lowest-index channel blocked at latch time
//   first_cnt         that channel's stall count at latch time

// One monitored channel: stall classification, saturating counter, block flag.
module rk4_axis_stall_lane #(
  parameter bit IS_IN        = 1'b0,
  parameter int CNT_W        = 16,
  parameter int STALL_THRESH = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             tvalid,
  input  logic             tready,
  output logic [CNT_W-1:0] cnt,
  output logic             block,
  output logic             block_nxt
);
  logic             stall;
  logic [CNT_W-1:0] cnt_nxt;

  // Inputs stall when the core is starved, outputs when it is back-pressured.
  assign stall = IS_IN ? (tready & ~tvalid) : (tvalid & ~tready);

  always_comb begin
    cnt_nxt = '0;
    if (enable && stall)
      cnt_nxt = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  end

  assign block_nxt = enable && (cnt_nxt >= CNT_W'(STALL_THRESH));

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt   <= '0;
      block <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      block <= block_nxt;
    end
  end
endmodule

module rk4_axis_stall_detector #(
  parameter int              NUM_CH       = 2,
  parameter logic [NUM_CH-1:0] IN_MASK    = 2'b01,
  parameter int              CNT_W        = 16,
  parameter int              STALL_THRESH = 1024,
  parameter int              CH_W         = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  rk4_axis_stall_detector_if.monitor axis,
  output logic [NUM_CH-1:0]    axis_block_sigs,
  output logic                 any_block,
  output logic                 first_valid,
  output logic [CH_W-1:0]      first_ch,
  output logic [CNT_W-1:0]     first_cnt
);
  typedef enum logic [1:0] {IDLE, ARMED, LATCHED} state_t;

  logic [NUM_CH-1:0][CNT_W-1:0] cnt;
  logic [NUM_CH-1:0]            block_nxt;
  state_t                       state, state_nxt;
  logic                         do_latch;
  logic [CH_W-1:0]              low_idx;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    rk4_axis_stall_lane #(
      .IS_IN       (IN_MASK[i]),
      .CNT_W       (CNT_W),
      .STALL_THRESH(STALL_THRESH)
    ) u_lane (
      .clock    (clock),
      .reset    (reset),
      .enable   (enable),
      .tvalid   (axis.ch_tvalid[i]),
      .tready   (axis.ch_tready[i]),
      .cnt      (cnt[i]),
      .block    (axis_block_sigs[i]),
      .block_nxt(block_nxt[i])
    );
  end

  // Register the OR of next-state flags so any_block lines up with the flags.
  always_ff @(posedge clock) begin
    if (reset) any_block <= 1'b0;
    else       any_block <= |block_nxt;
  end

  // Priority encode from the top so the lowest set index wins.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (axis_block_sigs[i]) low_idx = CH_W'(i);
  end

  always_comb begin
    state_nxt = state;
    do_latch  = 1'b0;
    case (state)
      IDLE:    if (enable) state_nxt = ARMED;
      ARMED: begin
        if (!enable) state_nxt = IDLE;
        else if (|axis_block_sigs) begin
          state_nxt = LATCHED;
          do_latch  = 1'b1;
        end
      end
      LATCHED: if (clear) state_nxt = enable ? ARMED : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      first_ch  <= '0;
      first_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (do_latch) begin
        first_ch  <= low_idx;
        first_cnt <= cnt[low_idx];
      end
    end
  end

  assign first_valid = (state == LATCHED);
endmodule

// File: tb/tb_rk4_axis_stall_detector.sv
// Directed bench for rk4_axis_stall_detector (NUM_CH=2, IN_MASK=01, CNT_W=4,
// STALL_THRESH=4). A run-length model of the stall rules is compared against
// the DUT every cycle; literal expectations at key points pin the model.
module tb_rk4_axis_stall_detector;
  localparam int          NUM_CH = 2;
  localparam logic [1:0]  INM    = 2'b01;
  localparam int          THR    = 4;
  localparam int          SAT    = 15;

  logic clock, reset, enable, clear;
  logic [1:0] block;
  logic       any_block, first_valid;
  logic [0:0] first_ch;
  logic [3:0] first_cnt;

  rk4_axis_stall_detector_if #(.NUM_CH(NUM_CH)) axis ();

  rk4_axis_stall_detector #(
    .NUM_CH(NUM_CH), .IN_MASK(INM), .CNT_W(4), .STALL_THRESH(THR), .CH_W(1)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .axis(axis.monitor),
    .axis_block_sigs(block), .any_block(any_block),
    .first_valid(first_valid), .first_ch(first_ch), .first_cnt(first_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: consecutive-stall run length per channel plus report state.
  int   m_run [NUM_CH];
  logic [1:0] m_block;
  int   m_st;        // 0 idle, 1 armed, 2 latched
  int   m_fch, m_fcnt;
  logic started = 1'b0;

  function automatic int sat(input int r);
    return (r > SAT) ? SAT : r;
  endfunction

  always @(posedge clock) begin
    int   rn [NUM_CH];
    logic st;
    int   lo;
    for (int i = 0; i < NUM_CH; i++) begin
      st = INM[i] ? (axis.ch_tready[i] && !axis.ch_tvalid[i])
                  : (axis.ch_tvalid[i] && !axis.ch_tready[i]);
      rn[i] = (!enable || !st) ? 0 : ((m_run[i] > 1000) ? m_run[i] : m_run[i] + 1);
    end
    lo = m_block[0] ? 0 : 1;
    started <= 1'b1;
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) m_run[i] <= 0;
      m_block <= '0; m_st <= 0; m_fch <= 0; m_fcnt <= 0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_run[i]   <= rn[i];
        m_block[i] <= enable && (rn[i] >= THR);
      end
      if (m_st == 0) begin
        if (enable) m_st <= 1;
      end else if (m_st == 1) begin
        if (!enable) m_st <= 0;
        else if (m_block != 0) begin
          m_st <= 2; m_fch <= lo; m_fcnt <= sat(m_run[lo]);
        end
      end else if (clear) begin
        m_st <= enable ? 1 : 0;
      end
    end
  end

  // Single compare process, sampling on the falling edge.
  always @(negedge clock) begin
    if (started) begin
      chk("block",       32'(block),       32'(m_block));
      chk("any_block",   32'(any_block),   32'(m_block != 0));
      chk("first_valid", 32'(first_valid), 32'(m_st == 2));
      chk("first_ch",    32'(first_ch),    32'(m_fch));
      chk("first_cnt",   32'(first_cnt),   32'(m_fcnt));
    end
  end

  // n edges elapse with current inputs; returns 2 time units after the last edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic drv(input logic [1:0] v, input logic [1:0] r);
    axis.ch_tvalid = v;
    axis.ch_tready = r;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; cyc(1); clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0; drv(2'b00, 2'b00);
    cyc(2);
    chk("rst_block", 32'(block), 0);
    chk("rst_fv",    32'(first_valid), 0);
    chk("rst_fcnt",  32'(first_cnt), 0);
    reset = 1'b0; enable = 1'b1;
    cyc(1);

    // 1: ch0 starved for 4 cycles
    drv(2'b00, 2'b01);
    cyc(3); chk("t1_pre",   32'(block), 32'b00);
    cyc(1); chk("t1_block", 32'(block), 32'b01);
            chk("t1_any",   32'(any_block), 1);
            chk("t1_fv0",   32'(first_valid), 0);
    cyc(1); chk("t1_fv",    32'(first_valid), 1);
            chk("t1_fch",   32'(first_ch), 0);
            chk("t1_fcnt",  32'(first_cnt), 4);
    drv(2'b00, 2'b00);
    cyc(1); chk("t1_fall",  32'(block), 32'b00);
    pulse_clear(); chk("t5_clr_noblk", 32'(first_valid), 0);
    cyc(1);        chk("t5_stay0",     32'(first_valid), 0);

    // 2: ch1 back-pressured 3 cycles, then handshake
    drv(2'b10, 2'b00);
    cyc(3); chk("t2_noblk", 32'(block), 32'b00);
    drv(2'b10, 2'b10);
    cyc(1); chk("t2_hs",    32'(block), 32'b00);
    drv(2'b00, 2'b00); cyc(1);

    // 3: both channels stall together
    drv(2'b10, 2'b01);
    cyc(4); chk("t3_block", 32'(block), 32'b11);
    cyc(1); chk("t3_fch",   32'(first_ch), 0);
            chk("t3_fcnt",  32'(first_cnt), 4);
    drv(2'b00, 2'b00); cyc(1);
    pulse_clear();

    // 4: ch1 stalls 40 cycles, counter saturates
    drv(2'b10, 2'b00);
    cyc(40); chk("t4_block", 32'(block), 32'b10);
             chk("t4_fch",   32'(first_ch), 1);
             chk("t4_fcnt",  32'(first_cnt), 4);
    drv(2'b10, 2'b10);
    cyc(1);  chk("t4_fall",  32'(block), 32'b00);
             chk("t4_any",   32'(any_block), 0);

    // 5: clear while a new block is still asserted -> one-cycle gap, re-latch
    drv(2'b00, 2'b01);
    cyc(5);  chk("t5_hold_ch", 32'(first_ch), 1);
    pulse_clear(); chk("t5_gap", 32'(first_valid), 0);
    cyc(1);  chk("t5_relatch", 32'(first_valid), 1);
             chk("t5_fch",     32'(first_ch), 0);
             chk("t5_fcnt",    32'(first_cnt), 6);
    drv(2'b00, 2'b00); cyc(1);
    pulse_clear();

    // 6: reset at stall cycle 3, then resume
    drv(2'b00, 2'b01);
    cyc(3);
    reset = 1'b1; cyc(1); reset = 1'b0;
    chk("t6_rst_fv",  32'(first_valid), 0);
    chk("t6_rst_blk", 32'(block), 32'b00);
    cyc(3); chk("t6_pre",   32'(block), 32'b00);
    cyc(1); chk("t6_block", 32'(block), 32'b01);
    cyc(1); chk("t6_fcnt",  32'(first_cnt), 4);
    enable = 1'b0;
    cyc(1); chk("t6_en0",   32'(block), 32'b00);
            chk("t6_fvhold", 32'(first_valid), 1);
    pulse_clear(); chk("t6_idle", 32'(first_valid), 0);
    enable = 1'b1; drv(2'b00, 2'b00);
    cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
